// File: rtl/cond_exec_stage_if.sv
// cond_exec_stage_if -- bundle between the decode stage and the conditional
// execute stage.
//   master : drives the decoded instruction (in_valid, cond, control bits,
//            ALUFlags, FlagWrite) and the stall/flush controls; samples outputs
//   slave  : the execute stage; returns the registered, condition-gated
//            controls, the architectural NZCV register and the squash counter
interface cond_exec_stage_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [3:0]       cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic             MemRead;
  logic             MemToReg;
  logic             Branch;

  logic             out_valid;
  logic             RegWrite_q;
  logic             MemWrite_q;
  logic             MemRead_q;
  logic             MemToReg_q;
  logic             PCSrc_q;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] squash_cnt;

  modport master (
    output in_valid, stall, flush, cond, ALUFlags, FlagWrite,
           RegWrite, MemWrite, MemRead, MemToReg, Branch,
    input  out_valid, RegWrite_q, MemWrite_q, MemRead_q, MemToReg_q,
           PCSrc_q, Flags, squash_cnt
  );

  modport slave (
    input  in_valid, stall, flush, cond, ALUFlags, FlagWrite,
           RegWrite, MemWrite, MemRead, MemToReg, Branch,
    output out_valid, RegWrite_q, MemWrite_q, MemRead_q, MemToReg_q,
           PCSrc_q, Flags, squash_cnt
  );
endinterface

// File: rtl/cond_exec_stage.sv
// cond_exec_stage -- ARM-style conditional execute pipeline stage.
// Evaluates the 4-bit condition field against the architectural NZCV
// register, gates the side-effecting controls of the instruction, registers
// them with one cycle of latency, updates NZCV for executed flag-setting
// instructions and counts valid instructions whose condition failed.
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : cond_exec_stage_if.slave (instruction in, gated controls out)
module cond_exec_stage #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cond_exec_stage_if.slave  bus
);

  logic             w_accept;
  logic             w_cond_ex;
  logic             w_n, w_z, w_c, w_v;

  logic             r_out_valid;
  logic             r_reg_write;
  logic             r_mem_write;
  logic             r_mem_read;
  logic             r_mem_to_reg;
  logic             r_pc_src;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_squash_cnt;

  assign w_accept = bus.in_valid & ~bus.stall & ~bus.flush;

  // Condition is judged only against the committed flags; the ALU result of
  // the same instruction must not influence whether it executes.
  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_ex = 1'b0;
    case (bus.cond)
      4'h0: w_cond_ex = w_z;
      4'h1: w_cond_ex = ~w_z;
      4'h2: w_cond_ex = w_c;
      4'h3: w_cond_ex = ~w_c;
      4'h4: w_cond_ex = w_n;
      4'h5: w_cond_ex = ~w_n;
      4'h6: w_cond_ex = w_v;
      4'h7: w_cond_ex = ~w_v;
      4'h8: w_cond_ex = w_c & ~w_z;
      4'h9: w_cond_ex = ~w_c | w_z;
      4'hA: w_cond_ex = (w_n == w_v);
      4'hB: w_cond_ex = (w_n != w_v);
      4'hC: w_cond_ex = ~w_z & (w_n == w_v);
      4'hD: w_cond_ex = w_z | (w_n != w_v);
      4'hE: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;  // 4'hF reserved: never executes
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_pc_src     <= 1'b0;
      r_flags      <= 4'b0000;
      r_squash_cnt <= '0;
    end else if (bus.flush) begin
      // Flush wins over stall: the stage empties, flags/counter untouched.
      r_out_valid  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_pc_src     <= 1'b0;
    end else if (!bus.stall) begin
      // in_valid=0 yields a bubble; otherwise this is an accept.
      r_out_valid  <= bus.in_valid;
      r_reg_write  <= bus.in_valid & bus.RegWrite & w_cond_ex;
      r_mem_write  <= bus.in_valid & bus.MemWrite & w_cond_ex;
      r_mem_read   <= bus.in_valid & bus.MemRead  & w_cond_ex;
      r_mem_to_reg <= bus.in_valid & bus.MemToReg;
      r_pc_src     <= bus.in_valid & bus.Branch   & w_cond_ex;
      if (w_accept && w_cond_ex) begin
        if (bus.FlagWrite[1]) r_flags[3:2] <= bus.ALUFlags[3:2];
        if (bus.FlagWrite[0]) r_flags[1:0] <= bus.ALUFlags[1:0];
      end
      if (w_accept && !w_cond_ex && (r_squash_cnt != {CNT_W{1'b1}}))
        r_squash_cnt <= r_squash_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    // stall=1, flush=0: everything holds
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.RegWrite_q = r_reg_write;
  assign bus.MemWrite_q = r_mem_write;
  assign bus.MemRead_q  = r_mem_read;
  assign bus.MemToReg_q = r_mem_to_reg;
  assign bus.PCSrc_q    = r_pc_src;
  assign bus.Flags      = r_flags;
  assign bus.squash_cnt = r_squash_cnt;

endmodule

// File: tb/tb_cond_exec_stage.sv
// tb_cond_exec_stage -- table-driven bench for cond_exec_stage (CNT_W=4).
// Each record is driven on a falling edge, its expected outputs pushed to a
// scoreboard queue, and popped/compared one clock later.
module tb_cond_exec_stage;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;

  cond_exec_stage_if #(.CNT_W(CNT_W)) bus ();

  cond_exec_stage #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl packing: {out_valid, RegWrite_q, MemWrite_q, MemRead_q, MemToReg_q, PCSrc_q}
  typedef struct {
    string      name;
    logic       rst_n;
    logic       in_valid;
    logic       stall;
    logic       flush;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic [4:0] ctl;   // {RegWrite, MemWrite, MemRead, MemToReg, Branch}
    logic [5:0] e_ctrl;
    logic [3:0] e_flags;
    logic [3:0] e_cnt;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] ctrl;
    logic [3:0] flags;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_n        = v.rst_n;
    bus.in_valid = v.in_valid;
    bus.stall    = v.stall;
    bus.flush    = v.flush;
    bus.cond     = v.cond;
    bus.ALUFlags = v.alu;
    bus.FlagWrite = v.fw;
    {bus.RegWrite, bus.MemWrite, bus.MemRead, bus.MemToReg, bus.Branch} = v.ctl;
    e.name = v.name; e.ctrl = v.e_ctrl; e.flags = v.e_flags; e.cnt = v.e_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got.ctrl  = {bus.out_valid, bus.RegWrite_q, bus.MemWrite_q, bus.MemRead_q,
                 bus.MemToReg_q, bus.PCSrc_q};
    got.flags = bus.Flags;
    got.cnt   = bus.squash_cnt;
    e = exp_q.pop_front();
    n_vec++;
    if (got.ctrl !== e.ctrl || got.flags !== e.flags || got.cnt !== e.cnt) begin
      n_miss++;
      $display("FAIL %s: got ctrl=%b flags=%b cnt=%h, want ctrl=%b flags=%b cnt=%h",
               e.name, got.ctrl, got.flags, got.cnt, e.ctrl, e.flags, e.cnt);
    end
  endtask

  function automatic vec_t mk(string name, logic r, logic iv, logic st, logic fl,
                              logic [3:0] c, logic [3:0] a, logic [1:0] fw,
                              logic [4:0] ctl, logic [5:0] ec, logic [3:0] ef,
                              logic [3:0] en);
    vec_t v;
    v.name = name; v.rst_n = r; v.in_valid = iv; v.stall = st; v.flush = fl;
    v.cond = c; v.alu = a; v.fw = fw; v.ctl = ctl;
    v.e_ctrl = ec; v.e_flags = ef; v.e_cnt = en;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.cond = 4'h0; bus.ALUFlags = 4'h0; bus.FlagWrite = 2'b00;
    bus.RegWrite = 1'b0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    bus.MemToReg = 1'b0; bus.Branch = 1'b0;

    //            name         rst iv st fl cond  alu      fw     {rw,mw,mr,m2r,br} ctrl       flags    cnt
    tbl.push_back(mk("reset",    0, 1, 0, 0, 4'hE, 4'b1111, 2'b11, 5'b10000, 6'b000000, 4'b0000, 4'h0));
    tbl.push_back(mk("al_rw",    1, 1, 0, 0, 4'hE, 4'b0100, 2'b11, 5'b10000, 6'b110000, 4'b0100, 4'h0));
    tbl.push_back(mk("ne_fail",  1, 1, 0, 0, 4'h1, 4'b1111, 2'b11, 5'b01000, 6'b100000, 4'b0100, 4'h1));
    tbl.push_back(mk("bubble",   1, 0, 0, 0, 4'hE, 4'b0000, 2'b11, 5'b10000, 6'b000000, 4'b0100, 4'h1));
    tbl.push_back(mk("al_m2r",   1, 1, 0, 0, 4'hE, 4'b1000, 2'b11, 5'b00010, 6'b100010, 4'b1000, 4'h1));
    tbl.push_back(mk("lt_br",    1, 1, 0, 0, 4'hB, 4'b0011, 2'b01, 5'b00001, 6'b100001, 4'b1011, 4'h1));
    tbl.push_back(mk("stl_fls",  1, 1, 1, 1, 4'hE, 4'b0000, 2'b11, 5'b10000, 6'b000000, 4'b1011, 4'h1));
    tbl.push_back(mk("al_fw00",  1, 1, 0, 0, 4'hE, 4'b0000, 2'b00, 5'b10100, 6'b110100, 4'b1011, 4'h1));
    tbl.push_back(mk("stall",    1, 1, 1, 0, 4'hF, 4'b0000, 2'b11, 5'b00000, 6'b110100, 4'b1011, 4'h1));
    tbl.push_back(mk("setz",     1, 1, 0, 0, 4'hE, 4'b0100, 2'b11, 5'b10000, 6'b110000, 4'b0100, 4'h1));
    tbl.push_back(mk("eq_b2b",   1, 1, 0, 0, 4'h0, 4'b0000, 2'b11, 5'b10000, 6'b110000, 4'b0000, 4'h1));
    tbl.push_back(mk("eq_fail",  1, 1, 0, 0, 4'h0, 4'b1111, 2'b11, 5'b10000, 6'b100000, 4'b0000, 4'h2));
    tbl.push_back(mk("nv_fail",  1, 1, 0, 0, 4'hF, 4'b1111, 2'b11, 5'b10000, 6'b100000, 4'b0000, 4'h3));
    tbl.push_back(mk("setc",     1, 1, 0, 0, 4'hE, 4'b0010, 2'b11, 5'b10000, 6'b110000, 4'b0010, 4'h3));
    tbl.push_back(mk("hi_pass",  1, 1, 0, 0, 4'h8, 4'b0000, 2'b00, 5'b10000, 6'b110000, 4'b0010, 4'h3));
    tbl.push_back(mk("gt_br",    1, 1, 0, 0, 4'hC, 4'b0000, 2'b00, 5'b00001, 6'b100001, 4'b0010, 4'h3));
    tbl.push_back(mk("ls_fail",  1, 1, 0, 0, 4'h9, 4'b1111, 2'b11, 5'b10000, 6'b100000, 4'b0010, 4'h4));
    tbl.push_back(mk("ge_mw",    1, 1, 0, 0, 4'hA, 4'b0000, 2'b00, 5'b01000, 6'b101000, 4'b0010, 4'h4));
    tbl.push_back(mk("rst_mid",  0, 1, 1, 0, 4'hE, 4'b1111, 2'b11, 5'b10000, 6'b000000, 4'b0000, 4'h0));

    foreach (tbl[i]) apply(tbl[i]);

    // Saturation: 16 failing instructions then one more; counter stops at F.
    for (int i = 0; i < 17; i++) begin
      logic [3:0] want;
      want = (i >= 14) ? 4'hF : 4'(i + 1);
      apply(mk("sat", 1, 1, 0, 0, 4'hF, 4'b1111, 2'b11, 5'b10000,
               6'b100000, 4'b0000, want));
    end
    // Flushed failing instruction is not counted and empties the stage.
    apply(mk("sat_flush", 1, 1, 0, 1, 4'hF, 4'b0000, 2'b00, 5'b00000,
             6'b000000, 4'b0000, 4'hF));
    // Reset clears the saturated counter.
    apply(mk("sat_rst", 0, 0, 0, 0, 4'hE, 4'b0000, 2'b00, 5'b00000,
             6'b000000, 4'b0000, 4'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
